// File: rtl/ifm_pkg.sv
// Shared types and sizing helpers for the IFM window loader slice.
package ifm_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  function automatic int window_len(input int kernel_size, input int ifm_channel);
    return kernel_size * kernel_size * ifm_channel;
  endfunction

endpackage

// File: rtl/ifm_window_loader_if.sv
// Bundle of the SRAM-side capture inputs and the systolic-array window handshake.
interface ifm_window_loader_if
  import ifm_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int WINDOW_LEN = 27
);

  logic                             addr_valid;
  logic [DATA_WIDTH-1:0]            ifm_data;
  logic                             load_ready;
  logic [WINDOW_LEN*DATA_WIDTH-1:0] window_data;
  logic                             window_valid;
  logic                             window_ready;
  logic                             window_partial;
  logic                             overflow_err;

  modport master (
    input  addr_valid, ifm_data, window_ready,
    output load_ready, window_data, window_valid, window_partial, overflow_err
  );

  modport slave (
    output addr_valid, ifm_data, window_ready,
    input  load_ready, window_data, window_valid, window_partial, overflow_err
  );

endinterface

// File: rtl/ifm_valid_delay.sv
// Shift register that aligns addr_valid with the SRAM read data it refers to.
module ifm_valid_delay #(
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  din,
  output logic                  dout,
  output logic [RD_LATENCY-1:0] taps
);

  always_ff @(posedge clk) begin
    if (clr) begin
      taps <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < RD_LATENCY; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[RD_LATENCY-1];

endmodule

// File: rtl/ifm_window_loader.sv
// Captures SRAM read data into a KxKxC window and hands it to the systolic array.
module ifm_window_loader
  import ifm_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int IFM_CHANNEL = 3,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int RD_LATENCY  = 1
) (
  input logic                clk,
  input logic                rst_n,
  ifm_window_loader_if.master bus
);

  localparam int WINDOW_LEN = window_len(KERNEL_SIZE, IFM_CHANNEL);
  localparam int IDX_W      = $clog2(WINDOW_LEN + 1);

  state_t                state;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] slot [WINDOW_LEN];
  logic                  dv;
  logic                  dv_prev;
  logic [RD_LATENCY-1:0] dv_taps;

  ifm_valid_delay #(
    .RD_LATENCY(RD_LATENCY)
  ) u_valid_delay (
    .clk  (clk),
    .clr  (rst_n),
    .din  (bus.addr_valid),
    .dout (dv),
    .taps (dv_taps)
  );

  // A window is closed early when the read stream stops mid-window; the
  // unfilled tail is zeroed at that moment so old pixels never leak out.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state              <= COLLECT;
      wr_idx             <= '0;
      dv_prev            <= 1'b0;
      bus.window_valid   <= 1'b0;
      bus.window_partial <= 1'b0;
      bus.overflow_err   <= 1'b0;
      bus.load_ready     <= 1'b0;
      for (int i = 0; i < WINDOW_LEN; i++) begin
        slot[i] <= '0;
      end
    end else begin
      dv_prev        <= dv;
      bus.load_ready <= (state == COLLECT) && (wr_idx == '0) && (dv_taps == '0);
      case (state)
        COLLECT: begin
          if (dv) begin
            for (int i = 0; i < WINDOW_LEN; i++) begin
              if (wr_idx == IDX_W'(i)) slot[i] <= bus.ifm_data;
            end
            wr_idx <= wr_idx + IDX_W'(1);
            if (wr_idx == IDX_W'(WINDOW_LEN - 1)) begin
              state              <= FULL;
              bus.window_valid   <= 1'b1;
              bus.window_partial <= 1'b0;
            end
          end else if (dv_prev && (wr_idx != '0) && (wr_idx < IDX_W'(WINDOW_LEN))) begin
            for (int i = 0; i < WINDOW_LEN; i++) begin
              if (IDX_W'(i) >= wr_idx) slot[i] <= '0;
            end
            state              <= FULL;
            bus.window_valid   <= 1'b1;
            bus.window_partial <= 1'b1;
          end
        end

        FULL: begin
          if (bus.window_ready) begin
            state              <= COLLECT;
            bus.window_valid   <= 1'b0;
            bus.window_partial <= 1'b0;
            // Data landing on the handshake cycle opens the next window directly.
            if (dv) begin
              slot[0] <= bus.ifm_data;
              wr_idx  <= IDX_W'(1);
            end else begin
              wr_idx  <= '0;
            end
          end else if (dv) begin
            bus.overflow_err <= 1'b1;
          end
        end

        default: state <= COLLECT;
      endcase
    end
  end

  for (genvar g = 0; g < WINDOW_LEN; g++) begin : g_pack
    assign bus.window_data[g*DATA_WIDTH +: DATA_WIDTH] = slot[g];
  end

endmodule

// File: doc/ifm_window_loader.md
Name: ifm_window_loader

Overview:
- Sits directly downstream of the IFM address controller and the IFM SRAM read port.
- Tracks the controller's addr_valid through the SRAM read latency and captures each returned pixel.
- Packs one full KERNEL_SIZE x KERNEL_SIZE x IFM_CHANNEL window into a flat vector.
- Presents that vector to the systolic-array input with a valid/ready handshake.

Parameters:
- KERNEL_SIZE, 3: window height/width.
- IFM_CHANNEL, 3: channels per window.
- DATA_WIDTH, 16: bits per pixel.
- RD_LATENCY, 1: SRAM cycles from address to data; legal range 1..4.

Ports:
- clk  in  1: single clock; all logic on rising edge.
- rst_n  in  1: synchronous, active-high reset (1 = reset), sampled on the clk rising edge.
- addr_valid  in  1: from the address controller; high for every cycle an address is issued.
- ifm_data  in  DATA_WIDTH: SRAM read data, valid RD_LATENCY cycles after its addr_valid.
- load_ready  out  1: loader is empty and idle; the controller's load is gated with this.
- window_data  out  WINDOW_LEN*DATA_WIDTH: packed window; pixel 0 in bits [DATA_WIDTH-1:0].
- window_valid  out  1: window_data holds a complete window.
- window_ready  in  1: consumer accepts the window.
- window_partial  out  1: qualifies window_valid; window was closed early and zero-padded.
- overflow_err  out  1: sticky; data arrived while a window was waiting.

Behaviour:
- WINDOW_LEN = KERNEL_SIZE*KERNEL_SIZE*IFM_CHANNEL (27 with defaults).
- wr_idx is $clog2(WINDOW_LEN+1) bits wide, unsigned.
- Reset values:
  - window_valid, window_partial, overflow_err, load_ready = 0.
  - window_data = 0; wr_idx = 0; valid delay line cleared; state = COLLECT.
- Reset mid-window: discards all captured data and pipeline valids.
- load_ready is registered. It is 1 when all three hold: state==COLLECT, wr_idx==0, delay line all zero. It first rises the cycle after rst_n deasserts.
- Valid delay line:
  - dv = addr_valid delayed exactly RD_LATENCY cycles.
  - dv_prev = dv registered one more cycle.
- State COLLECT:
  - On dv=1: slot[wr_idx] <= ifm_data; wr_idx <= wr_idx+1.
  - If wr_idx==WINDOW_LEN-1 on that capture: next state FULL, window_valid=1, window_partial=0.
  - Early close, on dv==0 && dv_prev==1 && 0<wr_idx<WINDOW_LEN:
    - slots wr_idx..WINDOW_LEN-1 <= 0;
    - window_partial=1, window_valid=1;
    - next state FULL.
  - dv falling with wr_idx==0: no action.
- State FULL:
  - window_data and window_partial are held stable while window_valid=1 && window_ready=0.
  - Handshake (window_ready=1): window_valid <= 0, window_partial <= 0, wr_idx <= 0, state <= COLLECT.
  - Handshake and dv=1 in the same cycle: ifm_data is captured into slot 0 and wr_idx <= 1 (zero bubble).
  - dv=1 without handshake: data dropped, overflow_err <= 1. overflow_err clears only on reset.
- Latency: last pixel returns from SRAM at edge N; window_valid is high from edge N+1.
- The unused slot region is zeroed at the early close itself. Stale data from a prior window is never visible.

Decomposition:
- Shared package ifm_pkg:
  - WINDOW_LEN as a function of KERNEL_SIZE and IFM_CHANNEL;
  - state encoding COLLECT=1'b0, FULL=1'b1;
  - DATA_WIDTH default.
- One sub-module, ifm_valid_delay: parameterised RD_LATENCY-deep shift register taking addr_valid to dv, with synchronous active-high clear.
- Slot array and FSM stay in ifm_window_loader.

Test Plan:
- Full window, RD_LATENCY=1:
  - Stimulus: 27 consecutive addr_valid cycles; ifm_data = 1..27 one cycle later; window_ready held 1.
  - Response: window_valid for 1 cycle; slot0=1, slot26=27; window_partial=0.
- Backpressure:
  - Stimulus: window_ready=0 for 10 cycles after a full window.
  - Response: window_data unchanged; window_valid stays 1.
  - Then window_ready=1: valid drops next cycle; load_ready rises.
- Early close:
  - Stimulus: 6 addr_valid pulses, data 0xA0..0xA5, then addr_valid low.
  - Response: window_partial=1; slots 0..5 = 0xA0..0xA5; slots 6..26 = 0.
- Same-cycle handshake and capture:
  - Stimulus: second window's first pixel 0x55 returns on the window_ready cycle.
  - Response: no loss; next window slot0=0x55.
- Overflow:
  - Stimulus: window_ready=0; 2 further pixels arrive.
  - Response: overflow_err=1 and sticky; first window data intact.
- Reset mid-window, RD_LATENCY=3:
  - Stimulus: assert rst_n after 13 pixels.
  - Response: all outputs 0 next edge; a following 27-pixel burst yields a correct window with slot0 = the first post-reset pixel.
